// File: rtl/bcd_scan_display.sv
// bcd_scan_display
//   Display stage for the CPU output byte. A sequential double-dabble FSM
//   converts an 8-bit binary value to three BCD digits, one shift per clock.
//   The latched result drives a time-multiplexed 3-digit 7-segment display
//   with registered outputs and optional leading-zero blanking.
//
// Parameters
//   SCAN_DIV   clock cycles each digit stays enabled (>= 2)
//   ACTIVE_LOW 1: seg/an driven 0 when lit/enabled
//   BLANK_LZ   1: blank leading zeros (ones digit is never blanked)
//
// Ports
//   clk      rising-edge system clock
//   reset    asynchronous active-high reset
//   value    binary value, sampled when load is accepted in IDLE
//   load     conversion request strobe (ignored while busy)
//   busy     high while a conversion is in progress
//   done     one-cycle pulse coincident with the bcd_out update
//   bcd_out  latched result {hundreds, tens, ones}
//   seg      segments g..a, seg[0] = a
//   an       one-hot digit enable: [0] ones, [1] tens, [2] hundreds
module bcd_scan_display #(
   parameter int unsigned SCAN_DIV   = 1024,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter bit          BLANK_LZ   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  value,
   input  logic        load,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd_out,
   output logic [6:0]  seg,
   output logic [2:0]  an
);

   localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

   state_t      state, state_nxt;
   logic [7:0]  shift_q;
   logic [11:0] scratch_q;
   logic [11:0] scratch_adj;
   logic [2:0]  bit_cnt;

   logic [PW-1:0] presc;
   logic [1:0]    digit_idx;
   logic [3:0]    digit;
   logic          blank;
   logic [6:0]    pat;
   logic [2:0]    an_hot;

   // Add-3 correction applied to every scratch nibble before the shift.
   always_comb begin
      scratch_adj = scratch_q;
      for (int unsigned i = 0; i < 3; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = CONV;
         CONV:    if (bit_cnt == 3'd7) state_nxt = LATCH;
         LATCH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         bcd_out   <= '0;
         shift_q   <= '0;
         scratch_q <= '0;
         bit_cnt   <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state == LATCH);
         case (state)
            IDLE: begin
               if (load) begin
                  shift_q   <= value;
                  scratch_q <= '0;
                  bit_cnt   <= '0;
               end
            end
            CONV: begin
               // {scratch, shift} <<= 1 after the nibble correction
               scratch_q <= {scratch_adj[10:0], shift_q[7]};
               shift_q   <= {shift_q[6:0], 1'b0};
               bit_cnt   <= bit_cnt + 3'd1;
            end
            LATCH:   bcd_out <= scratch_q;
            default: ;
         endcase
      end
   end

   // Free-running scan prescaler; digit index advances on each wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc     <= '0;
         digit_idx <= '0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc     <= '0;
         digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_comb begin
      digit  = bcd_out[3:0];
      blank  = 1'b0;
      an_hot = 3'b001;
      case (digit_idx)
         2'd1: begin
            digit  = bcd_out[7:4];
            an_hot = 3'b010;
            blank  = BLANK_LZ && (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
         end
         2'd2: begin
            digit  = bcd_out[11:8];
            an_hot = 3'b100;
            blank  = BLANK_LZ && (bcd_out[11:8] == 4'd0);
         end
         default: ;
      endcase

      case (digit)
         4'd0:    pat = 7'h3F;
         4'd1:    pat = 7'h06;
         4'd2:    pat = 7'h5B;
         4'd3:    pat = 7'h4F;
         4'd4:    pat = 7'h66;
         4'd5:    pat = 7'h6D;
         4'd6:    pat = 7'h7D;
         4'd7:    pat = 7'h07;
         4'd8:    pat = 7'h7F;
         4'd9:    pat = 7'h6F;
         default: pat = 7'h00;
      endcase
      if (blank) pat = 7'h00;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg <= {7{ACTIVE_LOW}};
         an  <= {3{ACTIVE_LOW}};
      end else begin
         seg <= ACTIVE_LOW ? ~pat    : pat;
         an  <= ACTIVE_LOW ? ~an_hot : an_hot;
      end
   end

endmodule
